// File: rtl/msrv32_trap_sequencer_if.sv
// msrv32 trap sequencer bus: decoded exception flags, CSR enables,
// CSR control strobes and PC redirect select.
interface msrv32_trap_sequencer_if;
  logic       instr_valid_in;
  logic       illegal_instr_in;
  logic       misaligned_instr_in;
  logic       misaligned_load_in;
  logic       misaligned_store_in;
  logic       ecall_in;
  logic       ebreak_in;
  logic       mret_in;
  logic       mie_in;
  logic       meie_in;
  logic       mtie_in;
  logic       msie_in;
  logic       meip_in;
  logic       mtip_in;
  logic       msip_in;
  logic       set_cause_out;
  logic       set_epc_out;
  logic       mie_clear_out;
  logic       mie_set_out;
  logic       i_or_e_out;
  logic       misaligned_exception_out;
  logic       instret_inc_out;
  logic [3:0] cause_out;
  logic [1:0] pc_src_out;
  logic       flush_out;

  modport master (
    output instr_valid_in, illegal_instr_in,
    output misaligned_instr_in, misaligned_load_in,
    output misaligned_store_in, ecall_in,
    output ebreak_in, mret_in,
    output mie_in, meie_in, mtie_in, msie_in,
    output meip_in, mtip_in, msip_in,
    input  set_cause_out, set_epc_out,
    input  mie_clear_out, mie_set_out,
    input  i_or_e_out, misaligned_exception_out,
    input  instret_inc_out, cause_out,
    input  pc_src_out, flush_out
  );

  modport slave (
    input  instr_valid_in, illegal_instr_in,
    input  misaligned_instr_in, misaligned_load_in,
    input  misaligned_store_in, ecall_in,
    input  ebreak_in, mret_in,
    input  mie_in, meie_in, mtie_in, msie_in,
    input  meip_in, mtip_in, msip_in,
    output set_cause_out, set_epc_out,
    output mie_clear_out, mie_set_out,
    output i_or_e_out, misaligned_exception_out,
    output instret_inc_out, cause_out,
    output pc_src_out, flush_out
  );
endinterface

// File: rtl/msrv32_trap_sequencer.sv
// msrv32 machine-mode trap/mret sequencer (OPERATING/TRAP_TAKEN/TRAP_RETURN).
// Define MSRV32_IRQ_SYNC_EN to double-flop meip/mtip/msip before use.
module msrv32_trap_sequencer (
  input logic clk_in,
  input logic rst_in,
  msrv32_trap_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    OPERATING   = 2'b00,
    TRAP_TAKEN  = 2'b01,
    TRAP_RETURN = 2'b10
  } state_e;

  state_e state_q, state_d;

  logic meip_w, mtip_w, msip_w;

`ifdef MSRV32_IRQ_SYNC_EN
  logic [2:0] sync1_q, sync2_q;

  // two-flop synchronizer on the asynchronous pending lines
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= {bus.meip_in, bus.mtip_in, bus.msip_in};
      sync2_q <= sync1_q;
    end
  end

  assign {meip_w, mtip_w, msip_w} = sync2_q;
`else
  assign meip_w = bus.meip_in;
  assign mtip_w = bus.mtip_in;
  assign msip_w = bus.msip_in;
`endif

  logic       exc, irq, mret;
  logic       mei, msi, mti;
  logic [3:0] exc_cause, irq_cause;
  logic       exc_mis;

  assign exc = bus.instr_valid_in &
               (bus.illegal_instr_in | bus.misaligned_instr_in |
                bus.misaligned_load_in | bus.misaligned_store_in |
                bus.ecall_in | bus.ebreak_in);

  assign mei = bus.meie_in & meip_w;
  assign msi = bus.msie_in & msip_w;
  assign mti = bus.mtie_in & mtip_w;

  assign irq  = bus.instr_valid_in & bus.mie_in & (mei | msi | mti);
  assign mret = bus.instr_valid_in & bus.mret_in;

  // exception cause by fixed priority; misaligned kinds flagged
  always_comb begin
    exc_cause = 4'd0;
    exc_mis   = 1'b0;
    if (bus.misaligned_instr_in) begin
      exc_cause = 4'd0;
      exc_mis   = 1'b1;
    end else if (bus.illegal_instr_in) begin
      exc_cause = 4'd2;
    end else if (bus.ecall_in) begin
      exc_cause = 4'd11;
    end else if (bus.ebreak_in) begin
      exc_cause = 4'd3;
    end else if (bus.misaligned_load_in) begin
      exc_cause = 4'd4;
      exc_mis   = 1'b1;
    end else if (bus.misaligned_store_in) begin
      exc_cause = 4'd6;
      exc_mis   = 1'b1;
    end
  end

  // interrupt cause: external beats software beats timer
  always_comb begin
    irq_cause = 4'd0;
    if (mei)      irq_cause = 4'd11;
    else if (msi) irq_cause = 4'd3;
    else if (mti) irq_cause = 4'd7;
  end

  // state register; reset drops any redirect in progress
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= OPERATING;
    else         state_q <= state_d;
  end

  // next state and CSR/PC strobes; everything forced low in reset
  always_comb begin
    state_d                      = OPERATING;
    bus.set_cause_out            = 1'b0;
    bus.set_epc_out              = 1'b0;
    bus.mie_clear_out            = 1'b0;
    bus.mie_set_out              = 1'b0;
    bus.i_or_e_out               = 1'b0;
    bus.misaligned_exception_out = 1'b0;
    bus.instret_inc_out          = 1'b0;
    bus.cause_out                = 4'd0;
    bus.pc_src_out               = 2'b00;
    bus.flush_out                = 1'b0;
    if (rst_in) begin
      unique case (state_q)
        OPERATING: begin
          if (exc) begin
            bus.set_cause_out            = 1'b1;
            bus.set_epc_out              = 1'b1;
            bus.mie_clear_out            = 1'b1;
            bus.cause_out                = exc_cause;
            bus.misaligned_exception_out = exc_mis;
            state_d                      = TRAP_TAKEN;
          end else if (irq) begin
            bus.set_cause_out = 1'b1;
            bus.set_epc_out   = 1'b1;
            bus.mie_clear_out = 1'b1;
            bus.i_or_e_out    = 1'b1;
            bus.cause_out     = irq_cause;
            state_d           = TRAP_TAKEN;
          end else if (mret) begin
            bus.mie_set_out     = 1'b1;
            bus.instret_inc_out = 1'b1;
            state_d             = TRAP_RETURN;
          end else if (bus.instr_valid_in) begin
            bus.instret_inc_out = 1'b1;
          end
        end
        TRAP_TAKEN: begin
          bus.pc_src_out = 2'b01;
          bus.flush_out  = 1'b1;
        end
        TRAP_RETURN: begin
          bus.pc_src_out = 2'b10;
          bus.flush_out  = 1'b1;
        end
        default: state_d = OPERATING;
      endcase
    end
  end

endmodule
